// File: rtl/collision_detector_pkg.sv
// collision_detector_pkg: shared state type, geometry constants and pixel-stage record.
package collision_detector_pkg;
  localparam int BALL_SIZE = 20;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  typedef enum logic [1:0] {IDLE, ACCUM, EVAL, COOLDOWN} state_t;
  typedef struct packed {
    logic       de;
    logic       paddle;
    logic       upscale;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] bx;
    logic [9:0] by;
  } pix_t;
endpackage

// File: rtl/collision_detector_frame_sync.sv
// frame_sync_detect: registered one-clock pulses for the first and last active pixel of a frame.
module frame_sync_detect
  import collision_detector_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       de,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  output logic       frame_start,
  output logic       frame_end
);
  logic start_d, start_q, end_d, end_q;
  always_comb begin
    start_d = de && x_pixel == 10'd0 && y_pixel == 10'd0;
    end_d   = de && x_pixel == 10'(H_ACTIVE - 1) && y_pixel == 10'(V_ACTIVE - 1);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      end_q   <= end_d;
    end
  end
  assign frame_start = start_q;
  assign frame_end   = end_q;
endmodule

// File: rtl/collision_detector.sv
// collision_detector: counts paddle pixels inside the ball window per frame and
// reports a hit (with a frame-count cooldown) two clocks after the last active pixel.
module collision_detector
  import collision_detector_pkg::*;
#(
  parameter int unsigned HIT_THRESHOLD   = 40,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic        clk_25MHZ,
  input  logic        reset_n,
  input  logic        upscale,
  input  logic [9:0]  x_pixel,
  input  logic [9:0]  y_pixel,
  input  logic        DE,
  input  logic        paddle_pixel,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  output logic        collision_detected,
  output logic [11:0] hit_count,
  output logic        frame_done
);
  pix_t        pix_d, pix_q;
  state_t      state_d, state_q;
  logic [11:0] acc_d, acc_q, hit_d, hit_q;
  logic [15:0] cd_d, cd_q;
  logic [9:0]  bx_d, bx_q, by_d, by_q, sx, sy;
  logic        up_d, up_q, coll_d, coll_q, done_d, done_q;
  logic        start, fend, restart, in_win, hit_px;

  frame_sync_detect u_sync (
    .clk        (clk_25MHZ),
    .reset_n    (reset_n),
    .de         (DE),
    .x_pixel    (x_pixel),
    .y_pixel    (y_pixel),
    .frame_start(start),
    .frame_end  (fend)
  );

  // Pixel data is delayed one stage so it lines up with the registered sync pulses.
  always_comb begin
    pix_d   = '{DE, paddle_pixel, upscale, x_pixel, y_pixel, ball_x, ball_y};
    restart = start && state_q != EVAL;
    bx_d    = restart ? pix_q.bx : bx_q;
    by_d    = restart ? pix_q.by : by_q;
    up_d    = restart ? pix_q.upscale : up_q;
    sx      = up_d ? pix_q.x : {1'b0, pix_q.x[9:1]};
    sy      = up_d ? pix_q.y : {1'b0, pix_q.y[9:1]};
    in_win  = sx >= bx_d && {1'b0, sx} < {1'b0, bx_d} + 11'(BALL_SIZE) &&
              sy >= by_d && {1'b0, sy} < {1'b0, by_d} + 11'(BALL_SIZE);
    hit_px  = pix_q.de && pix_q.paddle && in_win;
    state_d = state_q;
    acc_d   = acc_q;
    cd_d    = cd_q;
    hit_d   = hit_q;
    coll_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, COOLDOWN: begin
        acc_d   = restart ? {11'd0, hit_px} : acc_q;
        state_d = restart ? ACCUM : state_q;
      end
      ACCUM: begin
        acc_d   = restart ? {11'd0, hit_px} : (hit_px && acc_q != 12'hFFF) ? acc_q + 12'd1 : acc_q;
        state_d = (fend && !restart) ? EVAL : ACCUM;
      end
      EVAL: begin
        hit_d  = acc_q;
        done_d = 1'b1;
        // A pending cooldown consumes this frame before any threshold test.
        if (cd_q != 16'd0) begin
          cd_d    = cd_q - 16'd1;
          state_d = cd_q == 16'd1 ? IDLE : COOLDOWN;
        end else if (acc_q >= 12'(HIT_THRESHOLD)) begin
          coll_d  = 1'b1;
          cd_d    = 16'(COOLDOWN_FRAMES);
          state_d = COOLDOWN_FRAMES == 0 ? IDLE : COOLDOWN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) begin
      pix_q   <= '0;
      state_q <= IDLE;
      acc_q   <= '0;
      cd_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      up_q    <= 1'b0;
      hit_q   <= '0;
      coll_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pix_q   <= pix_d;
      state_q <= state_d;
      acc_q   <= acc_d;
      cd_q    <= cd_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      up_q    <= up_d;
      hit_q   <= hit_d;
      coll_q  <= coll_d;
      done_q  <= done_d;
    end
  end

  assign collision_detected = coll_q;
  assign hit_count          = hit_q;
  assign frame_done         = done_q;
endmodule
